// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : clock_pkg
//  Purpose  : Shared types and constants for the digital clock mode
//             controller: mode encoding, time-field moduli and widths.
//  Revision : 1.0  initial release
// ============================================================================
package clock_pkg;

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        SET_H  = 3'd1,
        SET_M  = 3'd2,
        SET_AH = 3'd3,
        SET_AM = 3'd4
    } mode_t;

    localparam int SEC_MOD = 60;
    localparam int MIN_MOD = 60;
    localparam int HOUR_W  = 5;
    localparam int MIN_W   = 6;
    localparam int TMO_W   = 6;   // holds timeout values up to 63

endpackage
`default_nettype wire

// File: rtl/mod_counter.sv
`default_nettype none
// ============================================================================
//  Module   : mod_counter
//  Purpose  : Modulo-MOD up counter with synchronous clear and a wrap flag.
//  Ports    : clk, rst   - clock, synchronous active-high reset (to RST_VAL)
//             clr        - synchronous clear to 0 (priority over inc)
//             inc        - advance by one, wrapping MOD-1 -> 0
//             value      - current count
//             wrap       - inc && value == MOD-1 (carry into next field)
//  Revision : 1.0  initial release
// ============================================================================
module mod_counter #(
    parameter int MOD     = 60,
    parameter int WIDTH   = 6,
    parameter int RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] value,
    output logic             wrap
);

    localparam logic [WIDTH:0] c_mod = (WIDTH+1)'(MOD);

    logic [WIDTH-1:0] r_value;
    logic [WIDTH:0]   w_inc;
    logic             w_last;

    // The increment carries one extra bit so MOD == 2**WIDTH cannot alias.
    assign w_inc  = {1'b0, r_value} + (WIDTH+1)'(1);
    assign w_last = (w_inc == c_mod);
    assign wrap   = inc && w_last;
    assign value  = r_value;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_value <= WIDTH'(RST_VAL);
        end else if (clr) begin
            r_value <= '0;
        end else if (inc) begin
            r_value <= w_last ? '0 : w_inc[WIDTH-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/clock_mode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : clock_mode_ctrl
//  Purpose  : Timekeeping and run/set mode controller for the digital clock.
//             Owns hh:mm:ss and the alarm hh:mm, sequences the edit modes,
//             drives a blink phase and emits a one-cycle alarm trigger.
//  Ports    : clk, rst            - 40 MHz clock, synchronous active-high reset
//             sec_tick            - 1 Hz single-cycle tick
//             key_mode, key_inc   - debounced single-cycle key pulses
//             alarm_en            - alarm armed level
//             hour/minute/second  - current time
//             alm_hour/alm_min    - alarm time
//             mode                - RUN/SET_H/SET_M/SET_AH/SET_AM
//             blink               - blink phase of the edited field
//             alarm_trig          - one-cycle pulse when time hits alarm:00
//  Revision : 1.0  initial release
// ============================================================================
module clock_mode_ctrl
    import clock_pkg::*;
#(
    parameter int HOUR_MOD  = 24,
    parameter int ALM_H_RST = 7,
    parameter int ALM_M_RST = 0,
    parameter int TIMEOUT_S = 30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sec_tick,
    input  logic              key_mode,
    input  logic              key_inc,
    input  logic              alarm_en,
    output logic [HOUR_W-1:0] hour,
    output logic [MIN_W-1:0]  minute,
    output logic [MIN_W-1:0]  second,
    output logic [HOUR_W-1:0] alm_hour,
    output logic [MIN_W-1:0]  alm_min,
    output logic [2:0]        mode,
    output logic              blink,
    output logic              alarm_trig
);

    localparam logic [TMO_W-1:0] c_timeout = TMO_W'(TIMEOUT_S);

    mode_t             r_mode, w_mode_nx;
    logic [TMO_W-1:0]  r_tmo, w_tmo_nx;
    logic              r_blink, w_blink_nx;
    logic              r_trig, w_trig_nx;

    logic w_set, w_running, w_enter_h, w_tick_run, w_edit, w_timeout;
    logic w_sec_wrap, w_min_wrap, w_hour_wrap;
    logic w_unused_ah_wrap, w_unused_am_wrap;
    logic [MIN_W-1:0]  w_min_nx;
    logic [HOUR_W-1:0] w_hour_nx;

    assign w_set     = (r_mode != RUN);
    assign w_running = (r_mode == RUN) || (r_mode == SET_AH) || (r_mode == SET_AM);
    // Entering SET_H restarts the second at 0, so a coincident tick is lost.
    assign w_enter_h  = (r_mode == RUN) && key_mode;
    assign w_tick_run = sec_tick && w_running && !w_enter_h;
    // key_mode takes priority over key_inc in the same cycle.
    assign w_edit     = key_inc && !key_mode;
    assign w_timeout  = w_set && (r_tmo == c_timeout) && !key_mode && !key_inc;

    // ------------------------------------------------------------------
    // Time and alarm fields
    // ------------------------------------------------------------------
    mod_counter #(.MOD(SEC_MOD), .WIDTH(MIN_W), .RST_VAL(0)) u_sec (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_enter_h),
        .inc   (w_tick_run),
        .value (second),
        .wrap  (w_sec_wrap)
    );

    mod_counter #(.MOD(MIN_MOD), .WIDTH(MIN_W), .RST_VAL(0)) u_min (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   (w_sec_wrap || (w_edit && (r_mode == SET_M))),
        .value (minute),
        .wrap  (w_min_wrap)
    );

    // Minute edits in SET_M also raise w_min_wrap; only a running-time
    // carry may reach the hour, hence the w_tick_run qualifier.
    mod_counter #(.MOD(HOUR_MOD), .WIDTH(HOUR_W), .RST_VAL(0)) u_hour (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   ((w_min_wrap && w_tick_run) || (w_edit && (r_mode == SET_H))),
        .value (hour),
        .wrap  (w_hour_wrap)
    );

    mod_counter #(.MOD(HOUR_MOD), .WIDTH(HOUR_W), .RST_VAL(ALM_H_RST)) u_alm_hour (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   (w_edit && (r_mode == SET_AH)),
        .value (alm_hour),
        .wrap  (w_unused_ah_wrap)
    );

    mod_counter #(.MOD(MIN_MOD), .WIDTH(MIN_W), .RST_VAL(ALM_M_RST)) u_alm_min (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   (w_edit && (r_mode == SET_AM)),
        .value (alm_min),
        .wrap  (w_unused_am_wrap)
    );

    // hh:mm that the time is about to take when the second wraps; the alarm
    // compares against this so the pulse lines up with the :00 edge.
    assign w_min_nx  = w_min_wrap ? '0 : minute + MIN_W'(1);
    assign w_hour_nx = w_min_wrap ? (w_hour_wrap ? '0 : hour + HOUR_W'(1)) : hour;

    // ------------------------------------------------------------------
    // Mode FSM, timeout counter, blink and alarm trigger
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode  <= RUN;
            r_tmo   <= '0;
            r_blink <= 1'b0;
            r_trig  <= 1'b0;
        end else begin
            r_mode  <= w_mode_nx;
            r_tmo   <= w_tmo_nx;
            r_blink <= w_blink_nx;
            r_trig  <= w_trig_nx;
        end
    end

    always_comb begin
        w_mode_nx  = r_mode;
        w_tmo_nx   = r_tmo;
        w_blink_nx = r_blink;
        w_trig_nx  = 1'b0;

        if (key_mode) begin
            case (r_mode)
                RUN:     w_mode_nx = SET_H;
                SET_H:   w_mode_nx = SET_M;
                SET_M:   w_mode_nx = SET_AH;
                SET_AH:  w_mode_nx = SET_AM;
                default: w_mode_nx = RUN;
            endcase
        end else if (w_timeout) begin
            w_mode_nx = RUN;
        end

        if (key_mode || key_inc || (w_mode_nx == RUN)) begin
            w_tmo_nx = '0;
        end else if (sec_tick) begin
            w_tmo_nx = r_tmo + TMO_W'(1);
        end

        if ((w_mode_nx == RUN) || key_mode || key_inc) begin
            w_blink_nx = 1'b0;
        end else if (sec_tick) begin
            w_blink_nx = !r_blink;
        end

        // Compared against the alarm registers as they stand before any
        // same-cycle alarm edit.
        w_trig_nx = w_sec_wrap && alarm_en &&
                    (w_hour_nx == alm_hour) && (w_min_nx == alm_min);
    end

    assign mode       = r_mode;
    assign blink      = r_blink;
    assign alarm_trig = r_trig;

endmodule
`default_nettype wire

// File: tb/tb_clock_mode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clock_mode_ctrl
//  Purpose  : Self-checking bench for clock_mode_ctrl: vector table, directed
//             corner sequences and random traffic against a seconds-of-day
//             reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_clock_mode_ctrl;

    localparam int HOUR_MOD  = 24;
    localparam int ALM_H_RST = 7;
    localparam int ALM_M_RST = 0;
    localparam int TIMEOUT_S = 30;
    localparam int DAY       = HOUR_MOD * 3600;

    logic       clk, rst, sec_tick, key_mode, key_inc, alarm_en;
    logic [4:0] hour, alm_hour;
    logic [5:0] minute, second, alm_min;
    logic [2:0] mode;
    logic       blink, alarm_trig;

    int n_tests = 0;
    int n_fail  = 0;
    bit g_en    = 0;

    // Reference state: time as seconds of day, alarm as minutes of day.
    int m_t, m_alm, m_mode, m_cnt;
    bit m_blink, m_trig;

    clock_mode_ctrl #(
        .HOUR_MOD(HOUR_MOD), .ALM_H_RST(ALM_H_RST),
        .ALM_M_RST(ALM_M_RST), .TIMEOUT_S(TIMEOUT_S)
    ) dut (
        .clk(clk), .rst(rst), .sec_tick(sec_tick), .key_mode(key_mode),
        .key_inc(key_inc), .alarm_en(alarm_en), .hour(hour), .minute(minute),
        .second(second), .alm_hour(alm_hour), .alm_min(alm_min), .mode(mode),
        .blink(blink), .alarm_trig(alarm_trig)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_step(input bit km, input bit ki, input bit st,
                              input bit en, input bit r);
        int m, nm;
        bit running, enter_h;
        if (r) begin
            m_t = 0; m_alm = ALM_H_RST * 60 + ALM_M_RST;
            m_mode = 0; m_cnt = 0; m_blink = 0; m_trig = 0;
            return;
        end
        m_trig  = 0;
        running = (m_mode == 0) || (m_mode == 3) || (m_mode == 4);
        enter_h = (m_mode == 0) && km;
        if (st && running && !enter_h) begin
            m_t = (m_t + 1) % DAY;
            if ((m_t % 60 == 0) && (m_t / 60 == m_alm) && en) m_trig = 1;
        end
        if (enter_h) m_t = m_t - (m_t % 60);
        if (ki && !km) begin
            case (m_mode)
                1: m_t = (m_t + 3600) % DAY;
                2: begin m = (m_t / 60) % 60; m_t = m_t - m * 60 + ((m + 1) % 60) * 60; end
                3: m_alm = (m_alm + 60) % (HOUR_MOD * 60);
                4: begin m = m_alm % 60; m_alm = m_alm - m + (m + 1) % 60; end
                default: ;
            endcase
        end
        nm = m_mode;
        if (km) nm = (m_mode + 1) % 5;
        else if ((m_mode != 0) && (m_cnt == TIMEOUT_S) && !ki) nm = 0;
        if (km || ki || nm == 0) m_cnt = 0;
        else if (st) m_cnt = m_cnt + 1;
        if (nm == 0 || km || ki) m_blink = 0;
        else if (st) m_blink = !m_blink;
        m_mode = nm;
    endtask

    task automatic check_val(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_model();
        logic [32:0] got, exp;
        got = {hour, minute, second, alm_hour, alm_min, mode, blink, alarm_trig};
        exp = {5'(m_t / 3600), 6'((m_t / 60) % 60), 6'(m_t % 60),
               5'(m_alm / 60), 6'(m_alm % 60), 3'(m_mode), m_blink, m_trig};
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL model @%0t: got h%0d m%0d s%0d ah%0d am%0d mode%0d b%0d t%0d expected h%0d m%0d s%0d ah%0d am%0d mode%0d b%0d t%0d",
                     $time, hour, minute, second, alm_hour, alm_min, mode, blink, alarm_trig,
                     m_t / 3600, (m_t / 60) % 60, m_t % 60, m_alm / 60, m_alm % 60,
                     m_mode, m_blink, m_trig);
        end
    endtask

    task automatic step(input bit km, input bit ki, input bit st,
                        input bit en, input bit r);
        key_mode = km; key_inc = ki; sec_tick = st; alarm_en = en; rst = r;
        @(posedge clk);
        model_step(km, ki, st, en, r);
        #1;
        check_model();
    endtask

    task automatic do_reset();   step(0, 0, 0, g_en, 1); endtask
    task automatic pulse_mode(); step(1, 0, 0, g_en, 0); endtask
    task automatic pulse_inc();  step(0, 1, 0, g_en, 0); endtask
    task automatic tick();       step(0, 0, 1, g_en, 0); endtask
    task automatic idle();       step(0, 0, 0, g_en, 0); endtask

    task automatic rand_phase(input int n, input int pkm, input int pki, input int pst);
        for (int i = 0; i < n; i++) begin
            bit km, ki, st, r;
            km = ($urandom_range(pkm - 1, 0) == 0);
            ki = ($urandom_range(pki - 1, 0) == 0);
            st = ($urandom_range(pst - 1, 0) == 0);
            r  = ($urandom_range(999, 0) == 0);
            if ($urandom_range(63, 0) == 0) g_en = !g_en;
            step(km, ki, st, g_en, r);
        end
    endtask

    typedef struct {
        bit km, ki, st;
        int mo, h, mi, s, ah, am, b;
    } vec_t;

    vec_t tbl [16];

    initial begin
        logic [31:0] got_v, exp_v;
        bit seen;

        tbl[0]  = '{0, 0, 1,  0, 0, 0, 1, 7, 0, 0};
        tbl[1]  = '{0, 0, 1,  0, 0, 0, 2, 7, 0, 0};
        tbl[2]  = '{1, 0, 1,  1, 0, 0, 0, 7, 0, 0};  // enter SET_H: tick lost, sec cleared
        tbl[3]  = '{0, 1, 0,  1, 1, 0, 0, 7, 0, 0};
        tbl[4]  = '{0, 0, 1,  1, 1, 0, 0, 7, 0, 1};  // frozen, blink toggles
        tbl[5]  = '{0, 1, 1,  1, 2, 0, 0, 7, 0, 0};  // key clears blink
        tbl[6]  = '{1, 1, 0,  2, 2, 0, 0, 7, 0, 0};  // mode beats inc
        tbl[7]  = '{0, 1, 0,  2, 2, 1, 0, 7, 0, 0};
        tbl[8]  = '{0, 0, 1,  2, 2, 1, 0, 7, 0, 1};
        tbl[9]  = '{1, 0, 1,  3, 2, 1, 0, 7, 0, 0};  // leaving SET_M: tick lost
        tbl[10] = '{0, 1, 1,  3, 2, 1, 1, 8, 0, 0};  // tick and alarm edit both apply
        tbl[11] = '{1, 0, 0,  4, 2, 1, 1, 8, 0, 0};
        tbl[12] = '{0, 1, 1,  4, 2, 1, 2, 8, 1, 0};
        tbl[13] = '{1, 0, 0,  0, 2, 1, 2, 8, 1, 0};
        tbl[14] = '{0, 1, 0,  0, 2, 1, 2, 8, 1, 0};  // inc ignored in RUN
        tbl[15] = '{0, 0, 1,  0, 2, 1, 3, 8, 1, 0};

        rst = 1; sec_tick = 0; key_mode = 0; key_inc = 0; alarm_en = 0;
        do_reset();
        do_reset();
        check_val("rst_mode", mode, 0);
        check_val("rst_hour", hour, 0);
        check_val("rst_second", second, 0);
        check_val("rst_alm_hour", alm_hour, ALM_H_RST);
        check_val("rst_alm_min", alm_min, ALM_M_RST);
        check_val("rst_blink", blink, 0);
        check_val("rst_trig", alarm_trig, 0);

        // Vector table
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].km, tbl[i].ki, tbl[i].st, 0, 0);
            got_v = {3'(mode), 5'(hour), 6'(minute), 6'(second), 5'(alm_hour), 6'(alm_min), 1'(blink)};
            exp_v = {3'(tbl[i].mo), 5'(tbl[i].h), 6'(tbl[i].mi), 6'(tbl[i].s),
                     5'(tbl[i].ah), 6'(tbl[i].am), 1'(tbl[i].b)};
            n_tests++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL vec%0d: got %h expected %h", i, got_v, exp_v);
            end
        end

        // Rollover 23:59:59 -> 00:00:00 with alarm at 07:00 armed
        g_en = 1;
        do_reset();
        pulse_mode();
        repeat (23) pulse_inc();
        pulse_mode();
        repeat (59) pulse_inc();
        repeat (3) pulse_mode();
        check_val("roll_mode", mode, 0);
        repeat (59) tick();
        check_val("roll_h59", hour, 23);
        check_val("roll_m59", minute, 59);
        check_val("roll_s59", second, 59);
        tick();
        check_val("roll_h0", hour, 0);
        check_val("roll_m0", minute, 0);
        check_val("roll_s0", second, 0);
        check_val("roll_trig", alarm_trig, 0);

        // Alarm at 00:01
        repeat (3) pulse_mode();
        repeat (17) pulse_inc();
        pulse_mode();
        pulse_inc();
        pulse_mode();
        check_val("alm_set_h", alm_hour, 0);
        check_val("alm_set_m", alm_min, 1);
        repeat (58) tick();
        check_val("alm_s58", second, 58);
        tick();
        check_val("alm_trig_early", alarm_trig, 0);
        tick();
        check_val("alm_trig_on", alarm_trig, 1);
        check_val("alm_min1", minute, 1);
        idle();
        check_val("alm_trig_off", alarm_trig, 0);
        // Same scenario disarmed, alarm at 00:02
        g_en = 0;
        repeat (4) pulse_mode();
        pulse_inc();
        pulse_mode();
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            seen = seen | alarm_trig;
        end
        check_val("alm_dis_min", minute, 2);
        check_val("alm_dis_trig", seen, 0);

        // Hour edit wraps at 24; time frozen in SET_M
        do_reset();
        pulse_mode();
        repeat (25) pulse_inc();
        pulse_mode();
        repeat (5) tick();
        check_val("set_hour", hour, 1);
        check_val("set_minute", minute, 0);
        check_val("set_second", second, 0);
        check_val("set_mode", mode, 2);

        // Timeout, then restart by key_inc
        do_reset();
        pulse_mode();
        for (int i = 0; i < 29; i++) begin tick(); idle(); end
        check_val("tmo_before", mode, 1);
        tick(); idle(); idle();
        check_val("tmo_mode", mode, 0);
        check_val("tmo_blink", blink, 0);
        pulse_mode();
        for (int i = 0; i < 29; i++) begin tick(); idle(); end
        pulse_inc();
        for (int i = 0; i < 29; i++) begin tick(); idle(); end
        check_val("tmo_restart_mode", mode, 1);
        check_val("tmo_restart_hour", hour, 1);
        tick(); idle(); idle();
        check_val("tmo_restart_run", mode, 0);

        // Reset in the middle of an alarm-minute edit
        do_reset();
        repeat (4) pulse_mode();
        repeat (45) step(0, 1, 1, g_en, 0);
        check_val("mid_alm_min", alm_min, 45);
        check_val("mid_second", second, 45);
        do_reset();
        check_val("mid_rst_mode", mode, 0);
        check_val("mid_rst_alm_h", alm_hour, ALM_H_RST);
        check_val("mid_rst_alm_m", alm_min, ALM_M_RST);
        check_val("mid_rst_sec", second, 0);
        check_val("mid_rst_blink", blink, 0);

        // Random traffic: busy keys, then sparse keys so timeouts occur
        g_en = 1;
        rand_phase(2000, 16, 4, 3);
        rand_phase(3000, 150, 100, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
